multdiv_unit: RTL

//  Iterative signed 32-bit multiply/divide unit in the execute stage, beside the single-cycle ALU.

---
 rtl/multdiv_pkg.sv | 17 +
 rtl/multdiv_iter_core.sv | 51 +++++
 rtl/multdiv_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the iterative signed multiply/divide unit.
package multdiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multdiv_iter_core.sv
// One shift-add (multiply) or restoring-subtract (divide) step on unsigned magnitudes,
// both ops sharing a single W+1-bit adder/subtractor.
module multdiv_iter_core
  import multdiv_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH
) (
  input  op_e          op_i,
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] shift_i,
  input  logic [W-1:0] mag_b_i,
  output logic [W-1:0] acc_o,
  output logic [W-1:0] shift_o
);

  logic [W:0] add_a;
  logic [W:0] add_b;
  logic       cin;
  logic [W:0] sum;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    add_a = {1'b0, acc_i};
    add_b = '0;
    cin   = 1'b0;
    if (op_i == OP_DIV) begin
      add_a = {acc_i, shift_i[W-1]};
      add_b = ~{1'b0, mag_b_i};
      cin   = 1'b1;
    end else if (shift_i[0]) begin
      add_b = {1'b0, mag_b_i};
    end
    sum = add_a + add_b + {{W{1'b0}}, cin};
  end

  always_comb begin
    acc_o   = sum[W:1];
    shift_o = {sum[0], shift_i[W-1:1]};
    if (op_i == OP_DIV) begin
      // A clear sign bit means the trial subtraction fit: keep it and shift in a 1.
      if (!sum[W]) begin
        acc_o   = sum[W-1:0];
        shift_o = {shift_i[W-2:0], 1'b1};
      end else begin
        acc_o   = add_a[W-1:0];
        shift_o = {shift_i[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide: FSM, counter, sign/magnitude pre-processing and result fix-up.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d, shift_q, shift_d, mag_b_q, mag_b_d;
  logic               neg_q, neg_d, bzero_q, bzero_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d, rdy_q, rdy_d;

  logic [WIDTH-1:0]   core_acc, core_shift;
  logic [2*WIDTH-1:0] prod_mag, prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic               issue;

  // -2^(W-1) maps to the unsigned value 2^(W-1), which still fits in W bits.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  multdiv_iter_core #(.W(WIDTH)) u_core (
    .op_i    (op_q),
    .acc_i   (acc_q),
    .shift_i (shift_q),
    .mag_b_i (mag_b_q),
    .acc_o   (core_acc),
    .shift_o (core_shift)
  );

  assign issue    = ctrl_MULT ^ ctrl_DIV;
  assign prod_mag = {acc_q, shift_q};
  assign prod_s   = neg_q ? (~prod_mag + 1'b1) : prod_mag;
  assign quot_s   = neg_q ? (~shift_q + 1'b1) : shift_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    shift_d  = shift_q;
    mag_b_d  = mag_b_q;
    neg_d    = neg_q;
    bzero_d  = bzero_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (issue) begin
      op_d    = ctrl_DIV ? OP_DIV : OP_MULT;
      cnt_d   = '0;
      acc_d   = '0;
      shift_d = mag(data_operandA);
      mag_b_d = mag(data_operandB);
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      bzero_d = (data_operandB == '0);
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          acc_d   = core_acc;
          shift_d = core_shift;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
        end
        // DONE is the sign fix-up cycle; result and RDY are registered on the edge leaving it.
        DONE: begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          if (op_q == OP_MULT) begin
            result_d = prod_s[WIDTH-1:0];
            exc_d    = !((&prod_s[2*WIDTH-1:WIDTH-1]) || !(|prod_s[2*WIDTH-1:WIDTH-1]));
          end else if (bzero_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = quot_s;
            exc_d    = !neg_q && shift_q[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      acc_q    <= '0;
      shift_q  <= '0;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      shift_q  <= shift_d;
      mag_b_q  <= mag_b_d;
      neg_q    <= neg_d;
      bzero_q  <= bzero_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != IDLE);

endmodule
